axi_arbiter_2to1: RTL and testbench
===================================

Name: axi_arbiter_2to1

Overview:
- Upstream neighbour of the CPU's AXI master port. Merges the ICache read-only AXI4 master (m0) and the DCache read/write AXI4 master (m1) into the single io_master AXI4 interface (s_*).
- The s_* interface feeds the AXI SRAM/DDR memory slave.
- Read bursts are arbitrated with a burst lock held until rlast.
- DCache writes pass straight through to s_*.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 64, AXI data width; strobe width is DATA_W/8.
- ID_W, 4, AXI ID width on s_*.
- M0_ID, 0, ARID driven on s_* for m0 bursts.
- M1_ID, 1, ARID/AWID driven on s_* for m1 bursts.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_arvalid/m0_arready  in/out  1/1  ICache AR handshake.
- m0_araddr/m0_arlen/m0_arsize/m0_arburst  in  ADDR_W/8/3/2  ICache AR payload.
- m0_rvalid/m0_rready  out/in  1/1  ICache R handshake.
- m0_rdata/m0_rresp/m0_rlast  out  DATA_W/2/1  ICache R payload.
- m1_ar*, m1_r*  same directions and widths as m0  DCache read channels.
- m1_awvalid/m1_awready  in/out  1/1  DCache AW handshake.
- m1_awaddr/m1_awlen/m1_awsize/m1_awburst  in  ADDR_W/8/3/2  DCache AW payload.
- m1_wvalid/m1_wready  in/out  1/1  DCache W handshake.
- m1_wdata/m1_wstrb/m1_wlast  in  DATA_W/DATA_W/8/1  DCache W payload.
- m1_bvalid/m1_bready  out/in  1/1  DCache B handshake.
- m1_bresp  out  2  DCache write response.
- s_arvalid/s_arready  out/in  1/1  merged AR handshake.
- s_arid/s_araddr/s_arlen/s_arsize/s_arburst  out  ID_W/ADDR_W/8/3/2  merged AR payload.
- s_rvalid/s_rready  in/out  1/1  merged R handshake.
- s_rid/s_rdata/s_rresp/s_rlast  in  ID_W/DATA_W/2/1  merged R payload.
- s_aw*, s_w*, s_b* (with s_awid/s_bid ID_W)  out/in mirror of m1 write  merged write channels.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. It forces rstate=R_IDLE and grant=M1, and clears the error flag.
- Outputs during and after reset: s_arvalid=0, m0/m1_arready=0, m0/m1_rvalid=0, s_rready=0, s_awvalid=0, s_wvalid=0, m1_bvalid=0.
- Read FSM states:
  - R_IDLE: if any mX_arvalid, register the winner into grant and go to R_ADDR. All arready stay 0.
  - R_ADDR: s_arvalid=m[grant]_arvalid. AR payload is combinationally muxed from m[grant]. s_arid=M0_ID or M1_ID. m[grant]_arready=s_arready; the other arready stays 0. On s_arvalid&s_arready go to R_DATA.
  - R_DATA: m[grant]_rvalid=s_rvalid and m[grant]_r* payload=s_r*. s_rready=m[grant]_rready. The other master's rvalid stays 0. On s_rvalid&s_rready&s_rlast go to R_IDLE.
- Latency: one-cycle arbitration bubble. mX_arvalid rising in R_IDLE at cycle N gives s_arvalid at N+1. Back-to-back bursts therefore have one idle cycle between rlast and the next s_arvalid.
- Priority (default): fixed, m1 (DCache) beats m0 when both are valid in R_IDLE. A master that loses keeps arvalid asserted; no request is ever dropped.
- Burst lock: the grant never changes outside R_IDLE. Single-beat bursts (arlen=0, rlast on the first beat) are legal.
- ID check: in R_DATA, if s_rvalid and s_rid != ID of the granted master, the beat is still routed by grant. An internal sticky rid_err is set, and a simulation assertion fires.
- Write path: purely combinational pass-through m1 -> s.
  - s_awid=M1_ID.
  - m1_bresp=s_bresp; s_bid is ignored.
  - Reads and writes proceed concurrently. DCache owns read-after-write ordering.
- Reset mid-burst: the FSM returns to R_IDLE immediately. The slave shares the same reset, so no beats are drained.
- Boundary: while reset is asserted, all valid/ready outputs are gated to 0.

Optional Feature:
- Macro: AXI_ARB_RR_EN.
- Defined: round-robin arbitration. A last_grant register (reset value M1) gives priority to the master not served last when both request in R_IDLE. last_grant updates when rlast is accepted.
- Undefined: fixed m1 > m0 priority as above; no last_grant register.

Decomposition:
- Shared package:
  - read FSM state enum {R_IDLE, R_ADDR, R_DATA};
  - grant encoding (M0=0, M1=1);
  - AXI burst/resp constants (INCR=2'b01, OKAY=2'b00).
- Sub-module axi_arb_picker (combinational): inputs req0, req1, last_grant; output winner. It holds the fixed or round-robin policy under the macro.
- The FSM and channel muxes stay in the top module.

Test Plan:
- m0 alone, araddr=0x8000_0000, arlen=3 -> s_arvalid at N+1 with s_arid=0. Four beats routed to m0. m1_rvalid never asserts. FSM is in R_IDLE the cycle after rlast.
- m0 and m1 request in the same cycle, default build -> m1 served first (s_arid=1, arlen=1). m0 is served next with s_arvalid exactly 1 cycle after m1's rlast. m0_arready stays 0 until then.
- Same collision with AXI_ARB_RR_EN, repeated 4 times -> grants alternate m0, m1, m0, m1; the first winner is m0 because last_grant resets to M1.
- m1 write (awaddr=0x8000_1000, wstrb=0xFF, 1 beat) during an m0 read burst -> write completes with m1_bvalid, s_awid=1. m0 read data is undisturbed.
- s_rid=1 injected during an m0 burst -> beat delivered to m0, rid_err set, assertion fires.
- reset asserted during beat 2 of an arlen=7 burst -> all valid/ready outputs 0 in the same cycle. After release, a new m1 request is granted normally.

Source files
------------

// File: rtl/axi_arbiter_2to1_pkg.sv
// -----------------------------------------------------------------------------
// axi_arbiter_2to1_pkg
// Shared types and constants for the 2:1 AXI read arbiter.
//   rstate_e     : read FSM states (idle / address phase / data phase)
//   grant_e      : which upstream master owns the read channels (M0 ICache, M1 DCache)
//   AXI_BURST_INCR, AXI_RESP_OKAY : common AXI encodings
//   other_master : returns the master that is not the one given
// Optional build macro used by users of this package: AXI_ARB_RR_EN
// -----------------------------------------------------------------------------
package axi_arbiter_2to1_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rstate_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } grant_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic grant_e other_master(input grant_e g);
        return (g == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/axi_arbiter_2to1_picker.sv
// -----------------------------------------------------------------------------
// axi_arb_picker
// Combinational arbitration policy for the read channel.
//   req0       in  : ICache (m0) read request
//   req1       in  : DCache (m1) read request
//   last_grant in  : master served by the most recent completed burst
//   winner     out : master to grant; only meaningful when req0 or req1 is set
// Build macro AXI_ARB_RR_EN selects round-robin; otherwise m1 has fixed
// priority over m0.
// -----------------------------------------------------------------------------
module axi_arb_picker
    import axi_arbiter_2to1_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  grant_e last_grant,
    output grant_e winner
);

`ifdef AXI_ARB_RR_EN
    // On a collision the master that was not served last goes first, so
    // neither cache can starve the other.
    always_comb begin
        winner = M1;
        if (req0 && req1) begin
            winner = other_master(last_grant);
        end else if (req0) begin
            winner = M0;
        end
    end
`else
    // The fixed policy has no memory, so last_grant is deliberately ignored.
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == M1);

    // DCache misses stall the pipeline harder than ICache misses, so m1 wins.
    always_comb begin
        winner = M1;
        if (req0 && !req1) begin
            winner = M0;
        end
    end
`endif

endmodule

// File: rtl/axi_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// axi_arbiter_2to1
// Merges the ICache read-only AXI4 master (m0) and the DCache read/write AXI4
// master (m1) onto one AXI4 slave port (s_*).
//   clock, reset      : system clock, asynchronous active-high reset
//   m0_ar* / m0_r*    : ICache read address / read data channels
//   m1_ar* / m1_r*    : DCache read address / read data channels
//   m1_aw*/m1_w*/m1_b*: DCache write channels (passed straight through)
//   s_ar* / s_r*      : merged read channels towards memory
//   s_aw* / s_w* / s_b*: write channels towards memory
// Reads are arbitrated once per burst and the grant is locked until the beat
// carrying rlast is accepted. Build macro AXI_ARB_RR_EN enables round-robin
// arbitration; the default is fixed m1-over-m0 priority.
// -----------------------------------------------------------------------------
module axi_arbiter_2to1
    import axi_arbiter_2to1_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int M0_ID  = 0,
    parameter int M1_ID  = 1
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rlast,

    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rlast,

    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [1:0]          m1_bresp,

    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ID_W-1:0]     s_arid,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [ID_W-1:0]     s_rid,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rlast,

    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ID_W-1:0]     s_awid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [7:0]          s_awlen,
    output logic [2:0]          s_awsize,
    output logic [1:0]          s_awburst,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [ID_W-1:0]     s_bid,
    input  logic [1:0]          s_bresp
);

    localparam logic [ID_W-1:0] M0_ID_L = ID_W'(M0_ID);
    localparam logic [ID_W-1:0] M1_ID_L = ID_W'(M1_ID);

    rstate_e         rstate_q, rstate_d;
    grant_e          grant_q, grant_d;
    logic            rid_err_q, rid_err_d;
    grant_e          last_grant;
    grant_e          winner;
    logic [ID_W-1:0] granted_id;

    // Only m1 writes and there is a single outstanding writer, so the
    // returned write ID carries no information.
    logic unused_bid;
    assign unused_bid = ^s_bid;

`ifdef AXI_ARB_RR_EN
    grant_e last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= M1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign last_grant = M1;
`endif

    axi_arb_picker u_picker (
        .req0       (m0_arvalid),
        .req1       (m1_arvalid),
        .last_grant (last_grant),
        .winner     (winner)
    );

    assign granted_id = (grant_q == M1) ? M1_ID_L : M0_ID_L;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rstate_q  <= R_IDLE;
            grant_q   <= M1;
            rid_err_q <= 1'b0;
        end else begin
            rstate_q  <= rstate_d;
            grant_q   <= grant_d;
            rid_err_q <= rid_err_d;
        end
    end

    // Read FSM: the grant is sampled only in R_IDLE, which gives the
    // one-cycle arbitration bubble and locks the owner for the whole burst.
    always_comb begin
        rstate_d   = rstate_q;
        grant_d    = grant_q;
        rid_err_d  = rid_err_q;
`ifdef AXI_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        s_arvalid  = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        s_rready   = 1'b0;

        case (rstate_q)
            R_IDLE: begin
                if (m0_arvalid || m1_arvalid) begin
                    grant_d  = winner;
                    rstate_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (grant_q == M1) begin
                    s_arvalid  = m1_arvalid;
                    m1_arready = s_arready;
                end else begin
                    s_arvalid  = m0_arvalid;
                    m0_arready = s_arready;
                end
                if (s_arvalid && s_arready) begin
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (grant_q == M1) begin
                    m1_rvalid = s_rvalid;
                    s_rready  = m1_rready;
                end else begin
                    m0_rvalid = s_rvalid;
                    s_rready  = m0_rready;
                end
                // A stray ID is still routed by grant; the sticky flag just
                // records that the slave misbehaved.
                if (s_rvalid && (s_rid != granted_id)) begin
                    rid_err_d = 1'b1;
                end
                if (s_rvalid && s_rready && s_rlast) begin
                    rstate_d = R_IDLE;
`ifdef AXI_ARB_RR_EN
                    last_grant_d = grant_q;
`endif
                end
            end
            default: begin
                rstate_d = R_IDLE;
            end
        endcase

        if (reset) begin
            s_arvalid  = 1'b0;
            m0_arready = 1'b0;
            m1_arready = 1'b0;
            m0_rvalid  = 1'b0;
            m1_rvalid  = 1'b0;
            s_rready   = 1'b0;
        end
    end

    // Read payloads: AR is muxed by the locked grant, R fans out to both
    // masters and only the valid qualifies which one sees it.
    assign s_arid    = granted_id;
    assign s_araddr  = (grant_q == M1) ? m1_araddr  : m0_araddr;
    assign s_arlen   = (grant_q == M1) ? m1_arlen   : m0_arlen;
    assign s_arsize  = (grant_q == M1) ? m1_arsize  : m0_arsize;
    assign s_arburst = (grant_q == M1) ? m1_arburst : m0_arburst;

    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_rlast = s_rlast;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_rlast = s_rlast;

    // Write path is a straight wire-through; handshakes are gated by reset.
    assign s_awvalid  = m1_awvalid & ~reset;
    assign m1_awready = s_awready  & ~reset;
    assign s_awid     = M1_ID_L;
    assign s_awaddr   = m1_awaddr;
    assign s_awlen    = m1_awlen;
    assign s_awsize   = m1_awsize;
    assign s_awburst  = m1_awburst;
    assign s_wvalid   = m1_wvalid  & ~reset;
    assign m1_wready  = s_wready   & ~reset;
    assign s_wdata    = m1_wdata;
    assign s_wstrb    = m1_wstrb;
    assign s_wlast    = m1_wlast;
    assign m1_bvalid  = s_bvalid   & ~reset;
    assign s_bready   = m1_bready  & ~reset;
    assign m1_bresp   = s_bresp;

    // Flag the first beat whose ID does not belong to the current owner.
    always @(posedge clock) begin
        if (!reset && (rstate_q == R_DATA) && s_rvalid && !rid_err_q) begin
            assert (s_rid == granted_id)
                else $warning("[ARB] s_rid %0h does not match granted id %0h", s_rid, granted_id);
        end
    end

endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// tb_axi_arbiter_2to1
// Self-checking bench for axi_arbiter_2to1. A small reference model decides
// which master must be served first (fixed m1 priority, or round-robin when
// AXI_ARB_RR_EN is defined) and the bench plays the memory slave.
// -----------------------------------------------------------------------------
module tb_axi_arbiter_2to1;
    import axi_arbiter_2to1_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ID_W   = 4;

    logic clock, reset;
    logic m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [ADDR_W-1:0] m0_araddr;
    logic [7:0] m0_arlen;
    logic [2:0] m0_arsize;
    logic [1:0] m0_arburst, m0_rresp;
    logic [DATA_W-1:0] m0_rdata;
    logic m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [ADDR_W-1:0] m1_araddr;
    logic [7:0] m1_arlen;
    logic [2:0] m1_arsize;
    logic [1:0] m1_arburst, m1_rresp;
    logic [DATA_W-1:0] m1_rdata;
    logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
    logic [ADDR_W-1:0] m1_awaddr;
    logic [7:0] m1_awlen;
    logic [2:0] m1_awsize;
    logic [1:0] m1_awburst, m1_bresp;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W/8-1:0] m1_wstrb;
    logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [ID_W-1:0] s_arid, s_rid;
    logic [ADDR_W-1:0] s_araddr;
    logic [7:0] s_arlen;
    logic [2:0] s_arsize;
    logic [1:0] s_arburst, s_rresp;
    logic [DATA_W-1:0] s_rdata;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [ID_W-1:0] s_awid, s_bid;
    logic [ADDR_W-1:0] s_awaddr;
    logic [7:0] s_awlen;
    logic [2:0] s_awsize;
    logic [1:0] s_awburst, s_bresp;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W/8-1:0] s_wstrb;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit model_last;

    axi_arbiter_2to1 dut (
        .clock(clock), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
        .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp)
    );

    // 100 MHz style free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case a scenario ever loses its way
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Move one cycle forward and land just after the active edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [11:0] vr_outputs();
        return {s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready,
                s_awvalid, m1_awready, s_wvalid, m1_wready, m1_bvalid, s_bready};
    endfunction

    function automatic logic [DATA_W:0] rbeat_of(input bit who);
        return who ? {m1_rdata, m1_rlast} : {m0_rdata, m0_rlast};
    endfunction

    // Reference policy: who must be served first among the requesters
    function automatic bit expected_first(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef AXI_ARB_RR_EN
            return !model_last;
`else
            return 1'b1;
`endif
        end
        return r1;
    endfunction

    task automatic clear_inputs();
        m0_arvalid = 0; m0_araddr = '0; m0_arlen = '0; m0_arsize = 3'd3; m0_arburst = AXI_BURST_INCR;
        m0_rready = 0;
        m1_arvalid = 0; m1_araddr = '0; m1_arlen = '0; m1_arsize = 3'd2; m1_arburst = AXI_BURST_INCR;
        m1_rready = 0;
        m1_awvalid = 0; m1_awaddr = '0; m1_awlen = '0; m1_awsize = 3'd3; m1_awburst = AXI_BURST_INCR;
        m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0; m1_bready = 0;
        s_arready = 0; s_rvalid = 0; s_rid = '0; s_rdata = '0; s_rresp = AXI_RESP_OKAY; s_rlast = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bid = '0; s_bresp = AXI_RESP_OKAY;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        model_last = 1'b1;
    endtask

    // Serve one burst; entry is one cycle into the address phase for 'who'
    task automatic serve(input bit who, input logic [ADDR_W-1:0] addr, input logic [7:0] len);
        logic [ID_W-1:0]   exp_id;
        logic [DATA_W-1:0] data;
        logic              rdy;
        bit                accepted;
        int                waits;
        exp_id = who ? 4'd1 : 4'd0;
        total_cnt++;
        if ({s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst} !==
            {1'b1, exp_id, addr, len, (who ? 3'd2 : 3'd3), AXI_BURST_INCR})
            $display("[TB] FAIL serve_ar got %h exp %h",
                     {s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst},
                     {1'b1, exp_id, addr, len, (who ? 3'd2 : 3'd3), AXI_BURST_INCR});
        else pass_cnt++;
        waits = $urandom_range(0, 2);
        for (int i = 0; i < waits; i++) begin
            s_arready = 1'b0;
            #1;
            total_cnt++;
            if ({m0_arready, m1_arready, s_arvalid} !== 3'b001)
                $display("[TB] FAIL ar_wait got %b exp 001", {m0_arready, m1_arready, s_arvalid});
            else pass_cnt++;
            step();
        end
        s_arready = 1'b1;
        #1;
        total_cnt++;
        if ({m1_arready, m0_arready} !== {who, !who})
            $display("[TB] FAIL ar_ready got %b exp %b", {m1_arready, m0_arready}, {who, !who});
        else pass_cnt++;
        step();
        s_arready = 1'b0;
        if (who) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            waits = $urandom_range(0, 1);
            for (int i = 0; i < waits; i++) begin
                s_rvalid = 1'b0;
                #1;
                total_cnt++;
                if ({m0_rvalid, m1_rvalid, s_arvalid} !== 3'b000)
                    $display("[TB] FAIL r_gap got %b exp 000", {m0_rvalid, m1_rvalid, s_arvalid});
                else pass_cnt++;
                step();
            end
            data = {$urandom, $urandom};
            s_rvalid = 1'b1; s_rdata = data; s_rid = exp_id;
            s_rresp = AXI_RESP_OKAY; s_rlast = (b == int'(len));
            accepted = 1'b0;
            for (int t = 0; t < 4 && !accepted; t++) begin
                rdy = (t == 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (who) m1_rready = rdy; else m0_rready = rdy;
                #1;
                total_cnt++;
                if ({m0_rvalid, m1_rvalid, s_rready, m0_arready, m1_arready} !== {!who, who, rdy, 2'b00})
                    $display("[TB] FAIL r_route beat %0d got %b exp %b", b,
                             {m0_rvalid, m1_rvalid, s_rready, m0_arready, m1_arready}, {!who, who, rdy, 2'b00});
                else pass_cnt++;
                total_cnt++;
                if (rbeat_of(who) !== {data, (b == int'(len))})
                    $display("[TB] FAIL r_data beat %0d got %h exp %h", b, rbeat_of(who), {data, (b == int'(len))});
                else pass_cnt++;
                accepted = rdy;
                step();
            end
        end
        s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
        total_cnt++;
        if (dut.rstate_q !== R_IDLE)
            $display("[TB] FAIL idle_after_rlast got %0d exp %0d", dut.rstate_q, R_IDLE);
        else pass_cnt++;
        model_last = who;
    endtask

    // Raise requests in one cycle and serve them in the model's order
    task automatic request(input bit r0, input bit r1,
                           input logic [ADDR_W-1:0] a0, input logic [7:0] l0,
                           input logic [ADDR_W-1:0] a1, input logic [7:0] l1);
        bit first;
        first = expected_first(r0, r1);
        m0_arvalid = r0; m0_araddr = a0; m0_arlen = l0;
        m1_arvalid = r1; m1_araddr = a1; m1_arlen = l1;
        #1;
        total_cnt++;
        if ({s_arvalid, m0_arready, m1_arready} !== 3'b000)
            $display("[TB] FAIL arb_bubble got %b exp 000", {s_arvalid, m0_arready, m1_arready});
        else pass_cnt++;
        step();
        if (first) serve(1'b1, a1, l1); else serve(1'b0, a0, l0);
        if (r0 && r1) begin
            #1;
            total_cnt++;
            if ({s_arvalid, m0_arready, m1_arready} !== 3'b000)
                $display("[TB] FAIL loser_bubble got %b exp 000", {s_arvalid, m0_arready, m1_arready});
            else pass_cnt++;
            step();
            if (first) serve(1'b0, a0, l0); else serve(1'b1, a1, l1);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        m0_arvalid = 1; m1_arvalid = 1; s_arready = 1; s_rvalid = 1; m0_rready = 1; m1_rready = 1;
        m1_awvalid = 1; s_awready = 1; m1_wvalid = 1; s_wready = 1; s_bvalid = 1; m1_bready = 1;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (vr_outputs() !== 12'h000)
            $display("[TB] FAIL reset_outputs got %h exp 000", vr_outputs());
        else pass_cnt++;
        total_cnt++;
        if ({dut.rstate_q, dut.grant_q, dut.rid_err_q} !== {R_IDLE, M1, 1'b0})
            $display("[TB] FAIL reset_state got %h exp %h", {dut.rstate_q, dut.grant_q, dut.rid_err_q}, {R_IDLE, M1, 1'b0});
        else pass_cnt++;
        clear_inputs();
        step();
        reset = 1'b0;
        step();
        total_cnt++;
        if (vr_outputs() !== 12'h000)
            $display("[TB] FAIL post_reset_outputs got %h exp 000", vr_outputs());
        else pass_cnt++;
        model_last = 1'b1;
    endtask

    task automatic test_single_m0();
        request(1'b1, 1'b0, 32'h8000_0000, 8'd3, 32'h0, 8'd0);
    endtask

    task automatic test_collision();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            request(1'b1, 1'b1, 32'h8000_0100 + 32'(i * 64), (i == 0) ? 8'd0 : 8'd2,
                    32'h8000_2000 + 32'(i * 64), 8'd1);
        end
    endtask

    task automatic test_random_arbitration();
        bit r0, r1;
        for (int i = 0; i < 10; i++) begin
            r0 = $urandom_range(0, 1);
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            request(r0, r1, {$urandom} & 32'hFFFF_FFF8, 8'($urandom_range(0, 3)),
                    {$urandom} & 32'hFFFF_FFF8, 8'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_write_during_read();
        logic [DATA_W-1:0] rd, wd;
        wd = {$urandom, $urandom};
        m0_arvalid = 1; m0_araddr = 32'h8000_0040; m0_arlen = 8'd3;
        step();
        s_arready = 1;
        step();
        s_arready = 0; m0_arvalid = 0;
        for (int b = 0; b < 4; b++) begin
            rd = {$urandom, $urandom};
            s_rvalid = 1; s_rdata = rd; s_rid = 4'd0; s_rlast = (b == 3); m0_rready = 1;
            case (b)
                0: begin
                    m1_awvalid = 1; m1_awaddr = 32'h8000_1000; m1_awlen = 8'd0; s_awready = 1;
                end
                1: begin
                    m1_awvalid = 0; s_awready = 0;
                    m1_wvalid = 1; m1_wdata = wd; m1_wstrb = 8'hFF; m1_wlast = 1; s_wready = 1;
                end
                2: begin
                    m1_wvalid = 0; s_wready = 0;
                    s_bvalid = 1; s_bresp = 2'b10; s_bid = 4'd1; m1_bready = 1;
                end
                default: begin
                    s_bvalid = 0; m1_bready = 0;
                end
            endcase
            #1;
            total_cnt++;
            if ({m0_rvalid, m1_rvalid, m0_rdata, m0_rlast} !== {1'b1, 1'b0, rd, (b == 3)})
                $display("[TB] FAIL wr_read_beat %0d got %h exp %h", b,
                         {m0_rvalid, m1_rvalid, m0_rdata, m0_rlast}, {1'b1, 1'b0, rd, (b == 3)});
            else pass_cnt++;
            total_cnt++;
            case (b)
                0: if ({s_awvalid, m1_awready, s_awid, s_awaddr, s_awlen} !== {2'b11, 4'd1, 32'h8000_1000, 8'd0})
                       $display("[TB] FAIL wr_aw got %h exp %h", {s_awvalid, m1_awready, s_awid, s_awaddr, s_awlen},
                                {2'b11, 4'd1, 32'h8000_1000, 8'd0});
                   else pass_cnt++;
                1: if ({s_wvalid, m1_wready, s_wdata, s_wstrb, s_wlast} !== {2'b11, wd, 8'hFF, 1'b1})
                       $display("[TB] FAIL wr_w got %h exp %h", {s_wvalid, m1_wready, s_wdata, s_wstrb, s_wlast},
                                {2'b11, wd, 8'hFF, 1'b1});
                   else pass_cnt++;
                2: if ({m1_bvalid, s_bready, m1_bresp} !== 4'b1110)
                       $display("[TB] FAIL wr_b got %b exp 1110", {m1_bvalid, s_bready, m1_bresp});
                   else pass_cnt++;
                default: if ({s_awvalid, s_wvalid, m1_bvalid} !== 3'b000)
                       $display("[TB] FAIL wr_idle got %b exp 000", {s_awvalid, s_wvalid, m1_bvalid});
                   else pass_cnt++;
            endcase
            step();
        end
        s_rvalid = 0; s_rlast = 0; m0_rready = 0;
        model_last = 1'b0;
    endtask

    task automatic test_rid_err();
        logic [DATA_W-1:0] rd;
        total_cnt++;
        if (dut.rid_err_q !== 1'b0)
            $display("[TB] FAIL rid_err_clear got %b exp 0", dut.rid_err_q);
        else pass_cnt++;
        m0_arvalid = 1; m0_araddr = 32'h8000_0080; m0_arlen = 8'd1;
        step();
        s_arready = 1;
        step();
        s_arready = 0; m0_arvalid = 0;
        rd = {$urandom, $urandom};
        s_rvalid = 1; s_rdata = rd; s_rid = 4'd1; s_rlast = 0; m0_rready = 1;
        #1;
        total_cnt++;
        if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, rd})
            $display("[TB] FAIL rid_route got %h exp %h", {m0_rvalid, m1_rvalid, m0_rdata}, {2'b10, rd});
        else pass_cnt++;
        step();
        total_cnt++;
        if (dut.rid_err_q !== 1'b1)
            $display("[TB] FAIL rid_err_set got %b exp 1", dut.rid_err_q);
        else pass_cnt++;
        s_rid = 4'd0; s_rlast = 1;
        step();
        s_rvalid = 0; s_rlast = 0; m0_rready = 0;
        #1;
        total_cnt++;
        if ({dut.rid_err_q, dut.rstate_q} !== {1'b1, R_IDLE})
            $display("[TB] FAIL rid_err_sticky got %h exp %h", {dut.rid_err_q, dut.rstate_q}, {1'b1, R_IDLE});
        else pass_cnt++;
        model_last = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        m0_arvalid = 1; m0_araddr = 32'h8000_0200; m0_arlen = 8'd7;
        step();
        s_arready = 1;
        step();
        s_arready = 0; m0_arvalid = 0;
        s_rvalid = 1; s_rid = 4'd0; m0_rready = 1;
        step();
        step();
        m1_arvalid = 1; s_arready = 1; m1_rready = 1;
        m1_awvalid = 1; s_awready = 1; m1_wvalid = 1; s_wready = 1; s_bvalid = 1; m1_bready = 1;
        #1;
        total_cnt++;
        if ({m0_rvalid, s_rready} !== 2'b11)
            $display("[TB] FAIL mid_burst_beat2 got %b exp 11", {m0_rvalid, s_rready});
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (vr_outputs() !== 12'h000)
            $display("[TB] FAIL mid_reset_outputs got %h exp 000", vr_outputs());
        else pass_cnt++;
        total_cnt++;
        if ({dut.rstate_q, dut.rid_err_q} !== {R_IDLE, 1'b0})
            $display("[TB] FAIL mid_reset_state got %h exp %h", {dut.rstate_q, dut.rid_err_q}, {R_IDLE, 1'b0});
        else pass_cnt++;
        clear_inputs();
        step();
        reset = 1'b0;
        step();
        model_last = 1'b1;
        request(1'b0, 1'b1, 32'h0, 8'd0, 32'h8000_3000, 8'd2);
    endtask

    initial begin
        reset = 1'b1;
        model_last = 1'b1;
        clear_inputs();
        test_reset();
        test_single_m0();
        test_collision();
        test_random_arbitration();
        test_write_during_read();
        test_rid_err();
        test_reset_mid_burst();
        $display("[TB] last master served: m%0d", model_last);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
